reg_write_register_table: RTL

- Write-side counterpart of the register read path.
- Consumes the byte stream delivered by the SPI receive byte buffer and assembles register write frames (address, data low, data high).
- Validates each frame and decodes the address into one-hot write strobes for the writable register bank.
- Status (0x00) and error (0x04) registers are read-only; writes to them are rejected.

---
 rtl/fpga_reg_pkg.sv | 40 ++++
 rtl/reg_frame_timer.sv | 29 ++
 rtl/reg_write_register_table.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fpga_reg_pkg.sv
// rtl/fpga_reg_pkg.sv - shared constants, frame state encoding and address check for the register write path
// Optional build macro: REG_WRITE_CHECKSUM_EN adds a 4th checksum byte to every frame.
package fpga_reg_pkg;

  localparam logic [7:0] STATUS_REG_ADDR = 8'h00;
  localparam logic [7:0] ERROR_REG_ADDR  = 8'h04;
  localparam logic [7:0] WREG_BASE_ADDR  = 8'h08;

`ifdef REG_WRITE_CHECKSUM_EN
  localparam int FRAME_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_ADDR,
    ST_GOT_LO,
    ST_GOT_HI,
    ST_COMMIT
  } frame_state_t;
`else
  localparam int FRAME_BYTES = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_ADDR,
    ST_GOT_LO,
    ST_COMMIT
  } frame_state_t;
`endif

  // True when addr names one of the writable registers; the read-only
  // status/error registers sit below the writable bank and are never accepted.
  function automatic logic addr_is_wreg(input logic [7:0] addr, input int num_wregs);
    logic [7:0] off;
    off = addr - WREG_BASE_ADDR;
    return (addr != STATUS_REG_ADDR) && (addr != ERROR_REG_ADDR) &&
           (addr >= WREG_BASE_ADDR) && (off[1:0] == 2'b00) &&
           (int'(off[7:2]) < num_wregs);
  endfunction

endpackage

// File: rtl/reg_frame_timer.sv
// rtl/reg_frame_timer.sv - inter-byte timeout counter for one register write frame
module reg_frame_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic sysClk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] count;

  assign expired = (count == TW'(TIMEOUT_CYCLES - 1));

  // Count idle cycles while a frame is open; hold at the limit until cleared.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_register_table.sv
// rtl/reg_write_register_table.sv - assembles SPI register write frames and decodes one-hot write strobes
// Optional build macro: REG_WRITE_CHECKSUM_EN (frame = addr, data_lo, data_hi, addr^lo^hi).
module reg_write_register_table
  import fpga_reg_pkg::*;
#(
  parameter int NUM_WREGS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 sysClk,
  input  logic                 reset,
  input  logic [7:0]           byte_in,
  input  logic                 byte_in_valid,
  input  logic                 cs_active,
  output logic [7:0]           reg_addr,
  output logic [15:0]          reg_data,
  output logic                 write_valid,
  output logic [NUM_WREGS-1:0] write_sel,
  output logic                 frame_error
);

  frame_state_t state, next_state;

  logic [7:0]           addr_q;
  logic [7:0]           lo_q;
  logic [15:0]          data_cand;
  logic                 cks_ok;
  logic                 byte_accept;
  logic                 waiting;
  logic                 timer_expired;
  logic                 abort_err;
  logic                 frame_done;
  logic [7:0]           addr_off;
  logic [NUM_WREGS-1:0] sel_dec;

  // A byte with chip select low is dropped in every state.
  assign byte_accept = byte_in_valid && cs_active;

`ifdef REG_WRITE_CHECKSUM_EN
  logic [7:0] hi_q;
  assign waiting   = (state == ST_GOT_ADDR) || (state == ST_GOT_LO) || (state == ST_GOT_HI);
  assign data_cand = {hi_q, lo_q};
  assign cks_ok    = (byte_in == (addr_q ^ lo_q ^ hi_q));
`else
  assign waiting   = (state == ST_GOT_ADDR) || (state == ST_GOT_LO);
  assign data_cand = {byte_in, lo_q};
  assign cks_ok    = 1'b1;
`endif

  reg_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .sysClk (sysClk),
    .reset  (reset),
    .clear  (byte_accept || !waiting || !cs_active),
    .enable (waiting),
    .expired(timer_expired)
  );

  // State register.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next state: abort beats a byte, a byte beats the timeout.
  always_comb begin
    next_state = state;
    abort_err  = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE, ST_COMMIT: begin
        next_state = byte_accept ? ST_GOT_ADDR : ST_IDLE;
      end
      ST_GOT_ADDR: begin
        if (!cs_active)         begin abort_err = 1'b1; next_state = ST_IDLE; end
        else if (byte_in_valid) next_state = ST_GOT_LO;
        else if (timer_expired) begin abort_err = 1'b1; next_state = ST_IDLE; end
      end
      ST_GOT_LO: begin
        if (!cs_active)         begin abort_err = 1'b1; next_state = ST_IDLE; end
`ifdef REG_WRITE_CHECKSUM_EN
        else if (byte_in_valid) next_state = ST_GOT_HI;
`else
        else if (byte_in_valid) begin frame_done = 1'b1; next_state = ST_COMMIT; end
`endif
        else if (timer_expired) begin abort_err = 1'b1; next_state = ST_IDLE; end
      end
`ifdef REG_WRITE_CHECKSUM_EN
      ST_GOT_HI: begin
        if (!cs_active)         begin abort_err = 1'b1; next_state = ST_IDLE; end
        else if (byte_in_valid) begin frame_done = 1'b1; next_state = ST_COMMIT; end
        else if (timer_expired) begin abort_err = 1'b1; next_state = ST_IDLE; end
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  // One-hot strobe for the assembled address; only used when the address checks out.
  always_comb begin
    addr_off = addr_q - WREG_BASE_ADDR;
    sel_dec  = '0;
    for (int k = 0; k < NUM_WREGS; k++) begin
      sel_dec[k] = (addr_off[7:2] == 6'(k));
    end
  end

  // Capture frame bytes as they are accepted.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      lo_q   <= '0;
`ifdef REG_WRITE_CHECKSUM_EN
      hi_q   <= '0;
`endif
    end else if (byte_accept) begin
      case (state)
        ST_IDLE, ST_COMMIT: addr_q <= byte_in;
        ST_GOT_ADDR:        lo_q   <= byte_in;
`ifdef REG_WRITE_CHECKSUM_EN
        ST_GOT_LO:          hi_q   <= byte_in;
`endif
        default: ;
      endcase
    end
  end

  // Outputs appear in the COMMIT cycle; error pulses in the cycle after an abort.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      reg_addr    <= '0;
      reg_data    <= '0;
      write_valid <= 1'b0;
      write_sel   <= '0;
      frame_error <= 1'b0;
    end else begin
      write_valid <= 1'b0;
      write_sel   <= '0;
      frame_error <= abort_err;
      if (frame_done) begin
        if (addr_is_wreg(addr_q, NUM_WREGS) && cks_ok) begin
          write_valid <= 1'b1;
          write_sel   <= sel_dec;
          reg_addr    <= addr_q;
          reg_data    <= data_cand;
        end else begin
          frame_error <= 1'b1;
        end
      end
    end
  end

endmodule
